// File: rtl/memory_write_port_pkg.sv
`default_nettype none
// ============================================================================
// Module  : memory_write_port_pkg
// Purpose : Store-size encodings, FSM state type and lane helper shared by the
//           store path (and by the load path for sign/zero extension).
// Revision: 1.0 - initial release
// ============================================================================
package memory_write_port_pkg;

    // Access size encodings carried on st_size
    localparam logic [1:0] c_sz_byte    = 2'b00;
    localparam logic [1:0] c_sz_half    = 2'b01;
    localparam logic [1:0] c_sz_word    = 2'b10;
    localparam logic [1:0] c_sz_illegal = 2'b11;

    // Write-port FSM states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_DONE  = 2'd2,
        S_ERR   = 2'd3
    } wp_state_t;

    // Physical byte lane for a byte offset; big-endian mirrors the lane order
    function automatic logic [1:0] lane_index(input logic [1:0] addr_lo,
                                              input logic       big_endian);
        return big_endian ? (2'd3 - addr_lo) : addr_lo;
    endfunction

endpackage : memory_write_port_pkg
`default_nettype wire

// File: rtl/memory_write_port_if.sv
`default_nettype none
// ============================================================================
// Module  : memory_write_port_if
// Purpose : Bundles the store request handshake from the control FSM and the
//           data-memory write bus. slave = the write port, master = its user.
// Revision: 1.0 - initial release
// ============================================================================
interface memory_write_port_if #(
    parameter int ADDR_W = 32
);
    logic              st_valid;
    logic              st_ready;
    logic [ADDR_W-1:0] st_addr;
    logic [31:0]       st_data;
    logic [1:0]        st_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_we;
    logic              mem_ack;
    logic              st_done;
    logic              st_misalign;
    logic              st_timeout;

    modport slave (
        input  st_valid, st_addr, st_data, st_size, mem_ack,
        output st_ready, mem_addr, mem_wdata, mem_be, mem_we,
               st_done, st_misalign, st_timeout
    );

    modport master (
        output st_valid, st_addr, st_data, st_size, mem_ack,
        input  st_ready, mem_addr, mem_wdata, mem_be, mem_we,
               st_done, st_misalign, st_timeout
    );
endinterface : memory_write_port_if
`default_nettype wire

// File: rtl/memory_write_port_store_align.sv
`default_nettype none
// ============================================================================
// Module  : memory_write_port_store_align
// Purpose : Combinational store aligner. Replicates store data across lanes,
//           builds byte enables and flags misaligned or illegal-size stores.
// Revision: 1.0 - initial release
// ============================================================================
module memory_write_port_store_align
    import memory_write_port_pkg::*;
#(
    parameter int BIG_ENDIAN = 0
) (
    input  wire logic [1:0]  i_addr_lo,
    input  wire logic [1:0]  i_size,
    input  wire logic [31:0] i_data,
    output logic      [31:0] o_wdata,
    output logic      [3:0]  o_be,
    output logic             o_misalign
);

    logic [1:0] w_lane;

    // Lane replication, byte-enable generation and alignment check
    always_comb begin
        w_lane     = lane_index(i_addr_lo, BIG_ENDIAN != 0);
        o_wdata    = i_data;
        o_be       = 4'b0000;
        o_misalign = 1'b0;
        case (i_size)
            c_sz_byte: begin
                o_wdata = {4{i_data[7:0]}};
                o_be    = 4'b0001 << w_lane;
            end
            c_sz_half: begin
                o_wdata    = {2{i_data[15:0]}};
                o_be       = w_lane[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_addr_lo[0];
            end
            c_sz_word: begin
                o_be       = 4'b1111;
                o_misalign = |i_addr_lo;
            end
            default: begin
                o_misalign = 1'b1;
            end
        endcase
    end

endmodule : memory_write_port_store_align
`default_nettype wire

// File: rtl/memory_write_port.sv
`default_nettype none
// ============================================================================
// Module  : memory_write_port
// Purpose : Store-side data-memory port of the multi-cycle MIPS datapath.
//           Accepts one store, holds the aligned write until ack or timeout,
//           then pulses done / misalign / timeout back to the control FSM.
// Revision: 1.0 - initial release
// ============================================================================
module memory_write_port
    import memory_write_port_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = 15,
    parameter int BIG_ENDIAN = 0
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    memory_write_port_if.slave bus
);

    localparam int c_cnt_w = $clog2(TIMEOUT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

    wp_state_t          r_state;
    wp_state_t          w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_is_timeout;
    logic [ADDR_W-1:0]  r_addr;
    logic [31:0]        r_wdata;
    logic [3:0]         r_be;

    logic [31:0]        w_wdata;
    logic [3:0]         w_be;
    logic               w_misalign;
    logic               w_accept;
    logic               w_expire;

    memory_write_port_store_align #(
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_align (
        .i_addr_lo  (bus.st_addr[1:0]),
        .i_size     (bus.st_size),
        .i_data     (bus.st_data),
        .o_wdata    (w_wdata),
        .o_be       (w_be),
        .o_misalign (w_misalign)
    );

    assign w_accept = (r_state == S_IDLE) && bus.st_valid;
    // Last wait cycle without ack; an ack in the same cycle still wins
    assign w_expire = (r_state == S_WRITE) && !bus.mem_ack && (r_cnt == c_cnt_last);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_next = w_misalign ? S_ERR : S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.mem_ack) begin
                    w_next = S_DONE;
                end else if (w_expire) begin
                    w_next = S_ERR;
                end
            end
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Capture address/data/enables on accept; wait counter and error cause
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_cnt        <= '0;
            r_is_timeout <= 1'b0;
        end else if (w_accept) begin
            r_addr       <= {bus.st_addr[ADDR_W-1:2], 2'b00};
            r_wdata      <= w_wdata;
            r_be         <= w_be;
            r_cnt        <= '0;
            r_is_timeout <= 1'b0;
        end else if ((r_state == S_WRITE) && !bus.mem_ack) begin
            r_cnt        <= r_cnt + 1'b1;
            r_is_timeout <= w_expire;
        end
    end

    // Outputs decoded from state so an async reset drops them immediately
    assign bus.st_ready    = (r_state == S_IDLE);
    assign bus.mem_we      = (r_state == S_WRITE);
    assign bus.mem_be      = (r_state == S_WRITE) ? r_be : 4'b0000;
    assign bus.mem_addr    = r_addr;
    assign bus.mem_wdata   = r_wdata;
    assign bus.st_done     = (r_state == S_DONE);
    assign bus.st_misalign = (r_state == S_ERR) && !r_is_timeout;
    assign bus.st_timeout  = (r_state == S_ERR) &&  r_is_timeout;

endmodule : memory_write_port
`default_nettype wire

// File: tb/tb_memory_write_port.sv
`default_nettype none
// ============================================================================
// Module  : tb_memory_write_port
// Purpose : Directed self-checking bench for memory_write_port (little- and
//           big-endian instances).
// Revision: 1.0 - initial release
// ============================================================================
module tb_memory_write_port;
    import memory_write_port_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    memory_write_port_if #(.ADDR_W(32)) bus ();
    memory_write_port_if #(.ADDR_W(32)) bus_be ();

    memory_write_port #(.ADDR_W(32), .TIMEOUT(15), .BIG_ENDIAN(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    memory_write_port #(.ADDR_W(32), .TIMEOUT(15), .BIG_ENDIAN(1)) dut_be (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_be)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a store for exactly one accepting edge
    task automatic store_accept(input logic [31:0] addr, input logic [31:0] data,
                                input logic [1:0] size);
        bus.st_valid = 1'b1;
        bus.st_addr  = addr;
        bus.st_data  = data;
        bus.st_size  = size;
        tick();
        bus.st_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int we_cnt;
        int done_cnt;
        int to_cnt;
        int mis_cnt;
        int to_at;
        int extra;

        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.st_valid = 1'b0; bus.st_addr = '0; bus.st_data = '0; bus.st_size = '0; bus.mem_ack = 1'b0;
        bus_be.st_valid = 1'b0; bus_be.st_addr = '0; bus_be.st_data = '0; bus_be.st_size = '0;
        bus_be.mem_ack = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_ready",  bus.st_ready, 1);
        chk("rst_we",     bus.mem_we, 0);
        chk("rst_be",     bus.mem_be, 0);
        chk("rst_addr",   bus.mem_addr, 0);
        chk("rst_wdata",  bus.mem_wdata, 0);
        chk("rst_flags",  {bus.st_done, bus.st_misalign, bus.st_timeout}, 0);
        rst_n = 1'b1;
        tick();

        // SW 0x1000, zero-wait ack: done in cycle 2, ready in cycle 3
        bus.mem_ack = 1'b1;
        store_accept(32'h1000, 32'hDEADBEEF, c_sz_word);
        chk("sw_we_c1",    bus.mem_we, 1);
        chk("sw_addr",     bus.mem_addr, 32'h1000);
        chk("sw_be",       bus.mem_be, 4'b1111);
        chk("sw_wdata",    bus.mem_wdata, 32'hDEADBEEF);
        chk("sw_ready_c1", bus.st_ready, 0);
        tick();
        bus.mem_ack = 1'b0;
        chk("sw_done_c2",  bus.st_done, 1);
        chk("sw_we_c2",    bus.mem_we, 0);
        chk("sw_be_c2",    bus.mem_be, 0);
        tick();
        chk("sw_ready_c3", bus.st_ready, 1);
        chk("sw_done_c3",  bus.st_done, 0);
        chk("sw_addr_hold", bus.mem_addr, 32'h1000);

        // SB 0x2003 on both endian instances
        bus_be.st_valid = 1'b1; bus_be.st_addr = 32'h2003; bus_be.st_data = 32'hA5;
        bus_be.st_size = c_sz_byte;
        store_accept(32'h2003, 32'h000000A5, c_sz_byte);
        bus_be.st_valid = 1'b0;
        chk("sb_be",        bus.mem_be, 4'b1000);
        chk("sb_wdata",     bus.mem_wdata, 32'hA5A5A5A5);
        chk("sb_addr",      bus.mem_addr, 32'h2000);
        chk("sb_big_be",    bus_be.mem_be, 4'b0001);
        chk("sb_big_wdata", bus_be.mem_wdata, 32'hA5A5A5A5);
        bus.mem_ack = 1'b1; bus_be.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0; bus_be.mem_ack = 1'b0;
        chk("sb_done", bus.st_done, 1);
        tick();

        // SH 0x3002 on both endian instances
        bus_be.st_valid = 1'b1; bus_be.st_addr = 32'h3002; bus_be.st_data = 32'h1234;
        bus_be.st_size = c_sz_half;
        store_accept(32'h3002, 32'h00001234, c_sz_half);
        bus_be.st_valid = 1'b0;
        chk("sh_be",        bus.mem_be, 4'b1100);
        chk("sh_wdata",     bus.mem_wdata, 32'h12341234);
        chk("sh_big_be",    bus_be.mem_be, 4'b0011);
        bus.mem_ack = 1'b1; bus_be.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0; bus_be.mem_ack = 1'b0;
        tick();

        // SH 0x3001 misaligned: misalign pulse, no write
        store_accept(32'h3001, 32'h00001234, c_sz_half);
        chk("shmis_pulse", bus.st_misalign, 1);
        chk("shmis_we",    bus.mem_we, 0);
        chk("shmis_to",    bus.st_timeout, 0);
        tick();
        chk("shmis_clear", bus.st_misalign, 0);
        chk("shmis_ready", bus.st_ready, 1);

        // Illegal size 11 rejected even when aligned
        store_accept(32'h0000, 32'h0, c_sz_illegal);
        chk("sz11_mis", bus.st_misalign, 1);
        chk("sz11_we",  bus.mem_we, 0);
        tick();

        // mem_ack in IDLE is ignored
        bus.mem_ack = 1'b1;
        tick();
        chk("idle_ack_done", bus.st_done, 0);
        chk("idle_ack_we",   bus.mem_we, 0);
        bus.mem_ack = 1'b0;
        tick();

        // Timeout: ack never arrives
        we_cnt = 0; to_cnt = 0; done_cnt = 0; mis_cnt = 0; to_at = -1;
        store_accept(32'h6000, 32'h11223344, c_sz_word);
        for (int i = 0; i < 20; i++) begin
            if (bus.mem_we) we_cnt++;
            if (bus.st_timeout) begin
                to_cnt++;
                if (to_at < 0) to_at = i;
            end
            if (bus.st_done) done_cnt++;
            if (bus.st_misalign) mis_cnt++;
            tick();
        end
        chk("to_we_cycles", we_cnt, 15);
        chk("to_pulses",    to_cnt, 1);
        chk("to_at_cycle",  to_at, 15);
        chk("to_no_done",   done_cnt, 0);
        chk("to_no_mis",    mis_cnt, 0);
        chk("to_ready",     bus.st_ready, 1);

        // Ack after 3 wait cycles with st_valid held high
        we_cnt = 0; done_cnt = 0; extra = 0;
        bus.st_valid = 1'b1; bus.st_addr = 32'h4000; bus.st_data = 32'hCAFEF00D;
        bus.st_size = c_sz_word;
        tick();
        for (int i = 0; i < 20; i++) begin
            if (bus.st_valid && bus.st_ready) extra++;
            if (bus.mem_we) begin
                we_cnt++;
                bus.mem_ack = (we_cnt == 4);
            end
            if (bus.st_done) begin
                done_cnt++;
                bus.st_valid = 1'b0;
                bus.mem_ack  = 1'b0;
            end
            tick();
        end
        bus.st_valid = 1'b0;
        chk("hold_we_cycles", we_cnt, 4);
        chk("hold_done_cnt",  done_cnt, 1);
        chk("hold_reaccept",  extra, 0);

        // Asynchronous reset during WRITE
        store_accept(32'h5000, 32'h55AA55AA, c_sz_word);
        tick();
        chk("rw_we_before", bus.mem_we, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rw_we_async",    bus.mem_we, 0);
        chk("rw_be_async",    bus.mem_be, 0);
        chk("rw_ready_async", bus.st_ready, 1);
        tick();
        rst_n = 1'b1;
        done_cnt = 0; to_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.st_done) done_cnt++;
            if (bus.st_timeout) to_cnt++;
            tick();
        end
        chk("rw_no_done", done_cnt, 0);
        chk("rw_no_to",   to_cnt, 0);
        chk("rw_ready",   bus.st_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_memory_write_port
`default_nettype wire
